seg7_count_display: RTL

//   Display-side reader of the 8-bit counter bus. Takes the live 8-bit count plus the
//   up/down flag and shows the count in decimal on a 4-digit, common-anode, multiplexed
//   7-segment display: digits 2..0 = hundreds/tens/units, digit 3 = direction glyph.

---
 rtl/seg7_count_display_pkg.sv | 33 +++
 rtl/seg7_count_display_if.sv | 22 ++
 rtl/seg7_count_display_bin2bcd.sv | 75 +++++++
 rtl/seg7_count_display.sv | 101 ++++++++++
 4 files changed

// File: rtl/seg7_count_display_pkg.sv
// Shared definitions for the counter display: converter states and 7-segment glyphs.
// Glyph bit order is {g,f,e,d,c,b,a}, active-low.
package seg7_count_display_pkg;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_LOAD
   } conv_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_UP    = 7'b1000001;
   localparam logic [6:0] SEG_DOWN  = 7'b0100001;

   function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
      logic [6:0] glyph;
      case (digit)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = SEG_BLANK;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Counter-bus / display-pin bundle between the counter (master) and the display driver (slave).
interface seg7_count_display_if;

   logic [7:0] value;
   logic       ud;
   logic       show_dir;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       bcd_upd;

   modport master (
      output value, ud, show_dir,
      input  seg, dp, an, bcd_upd
   );

   modport slave (
      input  value, ud, show_dir,
      output seg, dp, an, bcd_upd
   );

endinterface

// File: rtl/seg7_count_display_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter; reconverts whenever the input differs
// from the last value it converted and pulses done when the result is valid.
module seg7_count_display_bin2bcd
   import seg7_count_display_pkg::*;
(
   input  logic       clk50m,
   input  logic       reset,
   input  logic [7:0] value,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       done
);

   conv_state_t state;
   logic [7:0]  last_val;
   logic [7:0]  bin_sr;
   logic [11:0] acc;
   logic [11:0] adj_acc;
   logic [2:0]  bit_cnt;

   always_comb begin
      adj_acc = acc;
      for (int n = 0; n < 3; n++) begin
         if (acc[n*4 +: 4] >= 4'd5) begin
            adj_acc[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
         end
      end
   end

   // Input changes during SHIFT/LOAD are ignored; the IDLE compare catches them afterwards.
   always_ff @(posedge clk50m) begin
      if (reset) begin
         state    <= CONV_IDLE;
         last_val <= 8'd0;
         bin_sr   <= 8'd0;
         acc      <= 12'd0;
         bit_cnt  <= 3'd0;
         hundreds <= 4'd0;
         tens     <= 4'd0;
         units    <= 4'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CONV_IDLE: begin
               if (value != last_val) begin
                  bin_sr   <= value;
                  last_val <= value;
                  acc      <= 12'd0;
                  bit_cnt  <= 3'd0;
                  state    <= CONV_SHIFT;
               end
            end
            CONV_SHIFT: begin
               acc     <= {adj_acc[10:0], bin_sr[7]};
               bin_sr  <= {bin_sr[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state <= CONV_LOAD;
               end
            end
            CONV_LOAD: begin
               hundreds <= acc[11:8];
               tens     <= acc[7:4];
               units    <= acc[3:0];
               done     <= 1'b1;
               state    <= CONV_IDLE;
            end
            default: state <= CONV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg7_count_display.sv
// Multiplexed 4-digit common-anode display of the 8-bit count in decimal, with a
// direction glyph on digit 3 and optional leading-zero blanking.
module seg7_count_display
   import seg7_count_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit LZ_BLANK    = 1'b1
)
(
   input  logic                 clk50m,
   input  logic                 reset,
   seg7_count_display_if.slave  bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [PW-1:0] prescaler;
   logic          wrap;
   logic [1:0]    digit_idx;
   logic [1:0]    next_idx;
   logic [3:0]    conv_h, conv_t, conv_u;
   logic          conv_done;
   logic [3:0]    disp_h, disp_t, disp_u;
   logic [6:0]    next_glyph;
   logic [3:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_reg;
   logic          upd_reg;

   seg7_count_display_bin2bcd u_bin2bcd (
      .clk50m   (clk50m),
      .reset    (reset),
      .value    (bus.value),
      .hundreds (conv_h),
      .tens     (conv_t),
      .units    (conv_u),
      .done     (conv_done)
   );

   assign wrap     = (prescaler == PW'(REFRESH_DIV - 1));
   assign next_idx = digit_idx + 2'd1;

   // Glyph for the slot about to start; ud is therefore sampled at the digit-3 slot start.
   always_comb begin
      next_glyph = SEG_BLANK;
      case (next_idx)
         2'd0: next_glyph = digit_glyph(disp_u);
         2'd1: begin
            if (!(LZ_BLANK && disp_h == 4'd0 && disp_t == 4'd0)) begin
               next_glyph = digit_glyph(disp_t);
            end
         end
         2'd2: begin
            if (!(LZ_BLANK && disp_h == 4'd0)) begin
               next_glyph = digit_glyph(disp_h);
            end
         end
         2'd3: begin
            if (bus.show_dir) begin
               next_glyph = bus.ud ? SEG_UP : SEG_DOWN;
            end
         end
      endcase
   end

   always_ff @(posedge clk50m) begin
      if (reset) begin
         prescaler <= '0;
         digit_idx <= 2'd0;
         an_reg    <= 4'b1111;
         seg_reg   <= SEG_BLANK;
         dp_reg    <= 1'b1;
         upd_reg   <= 1'b0;
         disp_h    <= 4'd0;
         disp_t    <= 4'd0;
         disp_u    <= 4'd0;
      end else begin
         dp_reg  <= 1'b1;
         upd_reg <= conv_done;
         if (conv_done) begin
            disp_h <= conv_h;
            disp_t <= conv_t;
            disp_u <= conv_u;
         end
         if (wrap) begin
            prescaler <= '0;
            digit_idx <= next_idx;
            an_reg    <= ~(4'b0001 << next_idx);
            seg_reg   <= next_glyph;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   assign bus.an      = an_reg;
   assign bus.seg     = seg_reg;
   assign bus.dp      = dp_reg;
   assign bus.bcd_upd = upd_reg;

endmodule
